byte_data_memory: RTL
=====================

# byte_data_memory

Parametrised single-port data memory for the MIPS datapath, replacing the word-only data store. Supports byte/halfword/word loads and stores with sign or zero extension, a configurable read latency, misalignment and out-of-range detection, and a sequenced post-reset clear. It sits between the execute/memory stage and the register-file writeback mux, using a req/ready handshake so the pipeline can stall.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; any value ≥ 2, not required to be a power of two.
- READ_LAT, 1: cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req  in  1  request valid.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 illegal.
- unsigned_ld  in  1  1 = zero-extend loads (lbu/lhu); ignored for words and stores.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified: byte in [7:0], halfword in [15:0].
- ready  out  1  request accepted this cycle when req && ready.
- resp_valid  out  1  one-cycle response strobe, one per accepted request.
- rdata  out  32  load result, extended to 32 bits; 0 for stores and errored accesses.
- err  out  1  qualifies resp_valid: access was misaligned, out of range, or used size 11.
- init_busy  out  1  high while the post-reset clear runs.

## Operation
- Little-endian byte lanes. Word index = addr[31:2]; lane = addr[1:0].
- Error conditions: size 11; halfword with addr[0] = 1; word with addr[1:0] ≠ 0; addr[31:2] ≥ DEPTH_WORDS. An errored store writes nothing. An errored load returns rdata = 0. Both still produce resp_valid with err = 1.
- Stores write only the enabled lanes. Byte store replicates wdata[7:0] onto lane addr[1:0]. Halfword store writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
- Loads select the addressed lane(s) and right-justify them. Extension is sign (bit 7 or 15) unless unsigned_ld = 1.
- FSM states:
  - INIT: entered on reset. A counter walks word 0..DEPTH_WORDS-1, writing 0 one word per cycle. ready = 0 and init_busy = 1.
  - RUN: entered the cycle after the last word is cleared. ready = 1 continuously; the memory is single-port and fully pipelined.
- Response pipeline: a READ_LAT-deep shift register of {valid, err, is_load, extracted data}. Data is extracted at acceptance, so later stores do not alter an in-flight load result.
- Reset mid-INIT or mid-RUN: in-flight responses are discarded and INIT restarts from word 0.

## Timing
- Reset values: ready 0, resp_valid 0, rdata 0, err 0, init_busy 1; FSM = INIT, clear counter = 0.
- After resetN rises, init_busy stays high for exactly DEPTH_WORDS rising edges. ready rises on the following cycle.
- Request accepted at edge N produces resp_valid high for the single cycle after edge N+READ_LAT-1. For READ_LAT = 1, that is the cycle after acceptance.
- Stores commit at the acceptance edge.
- A load accepted on the cycle after a store to the same word returns the new data; there is no hazard window.
- Back-to-back requests every cycle give back-to-back responses in order.
- rdata and err are 0 whenever resp_valid = 0.

## Structure
- Package dmem_pkg holds:
  - enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD};
  - enum state_t {INIT, RUN};
  - function for lane-enable generation from size and addr[1:0].
- One sub-module, load_align: combinational lane select plus sign/zero extension (size, lane, unsigned_ld, word → 32-bit result). It is shared with any future instruction-side byte fetch.
- Top level contains the storage array, clear counter, FSM and response shift register.

## Test plan
- Reset with DEPTH_WORDS = 16, READ_LAT = 2:
  - init_busy high for 16 cycles, then ready = 1.
  - Load word at each of addresses 0x00..0x3C returns 0x00000000.
- Store word 0xA1B2C3D4 at 0x10, then:
  - lb 0x13 → 0xFFFFFFA1
  - lbu 0x13 → 0x000000A1
  - lh 0x12 → 0xFFFFA1B2
  - lhu 0x10 → 0x0000C3D4
- sb 0x5A at 0x11 after the store above, then lw 0x10 → 0xA1B25AD4.
- Error cases:
  - lh at 0x21 → err = 1, rdata = 0.
  - sw at 0x22 → err = 1, memory unchanged.
  - lw at 0x40 (DEPTH 16) → err = 1.
- Back-to-back streams:
  - sw 0x11111111 at 0x04, then lw 0x04 on the next cycle → 0x11111111.
  - Eight consecutive loads → eight consecutive resp_valid pulses, in order, READ_LAT cycles after issue.
- Reset mid-stream:
  - Assert resetN low with two loads in flight → no resp_valid after release, init_busy restarts.
  - Memory reads back as zero after INIT completes.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One stage of the response pipeline.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic        is_load;
    logic [31:0] data;
  } resp_t;

  localparam resp_t RESP_IDLE = '{valid: 1'b0, err: 1'b0, is_load: 1'b0, data: 32'h0000_0000};

  // Byte-lane write enables for an access of the given size at the given lane.
  function automatic logic [3:0] lane_enable(input size_t sz, input logic [1:0] lane);
    logic [3:0] en;
    case (sz)
      SZ_BYTE: en = 4'b0001 << lane;
      SZ_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Alignment / size legality check; size 11 is always treated as misaligned.
  function automatic logic misaligned(input size_t sz, input logic [1:0] lane);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_data_memory_load_align.sv
// Load-side lane select and sign/zero extension, shared with byte fetch paths.
module load_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane(s) and right-justify with the requested extension.
  always_comb begin
    byte_s = word[8*lane +: 8];
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size_t'(size))
      SZ_BYTE: result = {{24{byte_s[7] & ~unsigned_ld}}, byte_s};
      SZ_HALF: result = {{16{half_s[15] & ~unsigned_ld}}, half_s};
      SZ_WORD: result = word;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Single-port byte/halfword/word data memory with post-reset clear and a
// fixed-latency response pipeline behind a req/ready handshake.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        init_busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   mem_r [DEPTH_WORDS];
  state_t        state_r;
  logic [AW-1:0] clr_cnt_r;
  logic          ready_r;
  logic          init_busy_r;
  resp_t         pipe_r [READ_LAT];

  size_t         size_s;
  logic [AW-1:0] word_idx_s;
  logic          oor_s;
  logic          err_s;
  logic          accept_s;
  logic          store_s;
  logic [3:0]    lane_en_s;
  logic [31:0]   wdata_rep_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   ld_data_s;
  resp_t         resp_in_s;

  // Decode the request: legality, lane enables, replicated store data, read word.
  always_comb begin
    size_s     = size_t'(size);
    word_idx_s = addr[AW+1:2];
    oor_s      = (addr[31:2] >= 30'(DEPTH_WORDS));
    err_s      = oor_s | misaligned(size_s, addr[1:0]);
    accept_s   = req & ready_r;
    store_s    = accept_s & we & ~err_s;
    lane_en_s  = lane_enable(size_s, addr[1:0]);
    case (size_s)
      SZ_BYTE: wdata_rep_s = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep_s = {2{wdata[15:0]}};
      SZ_WORD: wdata_rep_s = wdata;
      default: wdata_rep_s = 32'h0000_0000;
    endcase
    if (oor_s) begin
      rd_word_s = 32'h0000_0000;
    end else begin
      rd_word_s = mem_r[word_idx_s];
    end
  end

  load_align u_load_align (
    .size        (size),
    .lane        (addr[1:0]),
    .unsigned_ld (unsigned_ld),
    .word        (rd_word_s),
    .result      (ld_data_s)
  );

  // Build the response entry at acceptance so later stores cannot alter it.
  always_comb begin
    resp_in_s = RESP_IDLE;
    if (accept_s) begin
      resp_in_s.valid   = 1'b1;
      resp_in_s.err     = err_s;
      resp_in_s.is_load = ~we;
      if (!we && !err_s) begin
        resp_in_s.data = ld_data_s;
      end else begin
        resp_in_s.data = 32'h0000_0000;
      end
    end else begin
      resp_in_s = RESP_IDLE;
    end
  end

  // Control FSM: walk the clear counter in INIT, then accept requests in RUN.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= INIT;
      clr_cnt_r   <= '0;
      ready_r     <= 1'b0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        INIT: begin
          if (clr_cnt_r == AW'(DEPTH_WORDS - 1)) begin
            state_r     <= RUN;
            ready_r     <= 1'b1;
            init_busy_r <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + AW'(1);
          end
        end
        RUN: begin
          ready_r     <= 1'b1;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= INIT;
          clr_cnt_r   <= '0;
          ready_r     <= 1'b0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  // Storage: zero one word per cycle during INIT, lane-masked stores in RUN.
  always_ff @(posedge clk) begin
    if (state_r == INIT) begin
      mem_r[clr_cnt_r] <= 32'h0000_0000;
    end else if (store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_rep_s[8*i +: 8];
        end
      end
    end
  end

  // Response shift register; reset drops anything in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_r[i] <= RESP_IDLE;
      end
    end else begin
      pipe_r[0] <= resp_in_s;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign ready      = ready_r;
  assign init_busy  = init_busy_r;
  assign resp_valid = pipe_r[READ_LAT-1].valid;
  assign err        = pipe_r[READ_LAT-1].valid & pipe_r[READ_LAT-1].err;
  assign rdata      = (pipe_r[READ_LAT-1].valid & pipe_r[READ_LAT-1].is_load)
                      ? pipe_r[READ_LAT-1].data : 32'h0000_0000;

endmodule
